// File: rtl/seq_bit_encoder_if.sv
// Handshake bundle for seq_bit_encoder: vector input channel and index output channel.
// The cnt signal exists only when ENC_POPCOUNT_EN is defined.
interface seq_bit_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  Z;
    logic [15:0] Y;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  X;
    logic        out_last;
    logic        err;
`ifdef ENC_POPCOUNT_EN
    logic [4:0]  cnt;
`endif

    modport master (
        output in_valid, Z, Y, out_ready,
`ifdef ENC_POPCOUNT_EN
        input  cnt,
`endif
        input  in_ready, out_valid, X, out_last, err
    );

    modport slave (
        input  in_valid, Z, Y, out_ready,
`ifdef ENC_POPCOUNT_EN
        output cnt,
`endif
        output in_ready, out_valid, X, out_last, err
    );
endinterface

// File: rtl/seq_bit_encoder.sv
// Serialises a multi-hot vector into one index beat per set bit, in priority order.
// Optional ENC_POPCOUNT_EN adds a cnt output holding the set-bit count of the vector.
module seq_bit_encoder #(
    parameter int unsigned PRIO_LSB = 1
) (
    input  logic              clk,
    input  logic              rst,
    seq_bit_encoder_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StEmit, StFlag} state_e;

    state_e      state_q;
    logic [15:0] vec_q;
    logic [3:0]  x_q;
    logic        last_q;
    logic        err_q;
    logic        valid_q;

    logic [15:0] in_mask;
    logic [15:0] in_masked;
    logic        in_bad;
    logic [15:0] vec_next;
    logic [3:0]  first_idx;
    logic [3:0]  next_idx;
    logic        first_single;
    logic        next_single;

    // Scan order picks which end of the vector wins when several bits are set.
    function automatic logic [3:0] pick_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (PRIO_LSB != 0) begin
                if (v[15-i]) idx = 4'(15 - i);
            end else begin
                if (v[i]) idx = 4'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_single(input logic [15:0] v);
        return (v != '0) && ((v & (v - 16'd1)) == '0);
    endfunction

    always_comb begin
        in_mask = '0;
        unique case (bus.Z)
            2'b00:   in_mask = 16'h000F;
            2'b01:   in_mask = 16'h00FF;
            2'b10:   in_mask = 16'hFFFF;
            default: in_mask = 16'h0000;
        endcase
        in_masked = bus.Y & in_mask;
        in_bad    = (bus.Z == 2'b11) || (in_masked == '0);
        vec_next  = vec_q & ~(16'd1 << x_q);
    end

    assign first_idx    = pick_idx(in_masked);
    assign next_idx     = pick_idx(vec_next);
    assign first_single = is_single(in_masked);
    assign next_single  = is_single(vec_next);

`ifdef ENC_POPCOUNT_EN
    logic [4:0] cnt_q;

    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] sum;
        sum = '0;
        for (int i = 0; i < 16; i++) begin
            sum = sum + 5'(v[i]);
        end
        return sum;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == StIdle && bus.in_valid) begin
            cnt_q <= in_bad ? 5'd0 : popcount(in_masked);
        end else if (state_q != StIdle && bus.out_ready && last_q) begin
            cnt_q <= '0;
        end
    end

    assign bus.cnt = cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            vec_q   <= '0;
            x_q     <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        valid_q <= 1'b1;
                        if (in_bad) begin
                            state_q <= StFlag;
                            vec_q   <= '0;
                            x_q     <= '0;
                            last_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= StEmit;
                            vec_q   <= in_masked;
                            x_q     <= first_idx;
                            last_q  <= first_single;
                            err_q   <= 1'b0;
                        end
                    end
                end
                StEmit: begin
                    if (bus.out_ready) begin
                        if (last_q) begin
                            state_q <= StIdle;
                            vec_q   <= '0;
                            x_q     <= '0;
                            last_q  <= 1'b0;
                            valid_q <= 1'b0;
                        end else begin
                            vec_q  <= vec_next;
                            x_q    <= next_idx;
                            last_q <= next_single;
                        end
                    end
                end
                StFlag: begin
                    if (bus.out_ready) begin
                        state_q <= StIdle;
                        x_q     <= '0;
                        last_q  <= 1'b0;
                        err_q   <= 1'b0;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = valid_q;
    assign bus.X         = x_q;
    assign bus.out_last  = last_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_seq_bit_encoder.sv
// Scoreboard bench for seq_bit_encoder: one LSB-first and one MSB-first instance.
// Define ENC_POPCOUNT_EN to also check cnt.
module tb_seq_bit_encoder;

    typedef struct packed {
        logic [3:0] x;
        logic       last;
        logic       err;
        logic [4:0] cnt;
    } beat_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_fail;
    beat_t sb[$];
    beat_t exp_b;

    seq_bit_encoder_if b_lsb();
    seq_bit_encoder_if b_msb();

    seq_bit_encoder #(.PRIO_LSB(1)) dut_lsb (.clk(clk), .rst(rst), .bus(b_lsb));
    seq_bit_encoder #(.PRIO_LSB(0)) dut_msb (.clk(clk), .rst(rst), .bus(b_msb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected beat list for one accepted vector.
    function automatic void push_exp(input bit prio_lsb, input logic [1:0] z,
                                     input logic [15:0] y);
        logic [15:0] m;
        int          total;
        int          seen;
        beat_t       b;
        case (z)
            2'b00:   m = y & 16'h000F;
            2'b01:   m = y & 16'h00FF;
            2'b10:   m = y;
            default: m = 16'h0000;
        endcase
        total = 0;
        for (int i = 0; i < 16; i++) total += int'(m[i]);
        if (z == 2'b11 || total == 0) begin
            b = '{x: 4'd0, last: 1'b1, err: 1'b1, cnt: 5'd0};
            sb.push_back(b);
            return;
        end
        seen = 0;
        for (int k = 0; k < 16; k++) begin
            int i;
            i = prio_lsb ? k : 15 - k;
            if (m[i]) begin
                seen++;
                b = '{x: 4'(i), last: (seen == total), err: 1'b0, cnt: 5'(total)};
                sb.push_back(b);
            end
        end
    endfunction

    task automatic send_lsb(input logic [1:0] z, input logic [15:0] y);
        @(negedge clk);
        n_vec++;
        if (b_lsb.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL in_ready_before_send: got %b want 1", b_lsb.in_ready);
        end
        b_lsb.Z = z;
        b_lsb.Y = y;
        b_lsb.in_valid = 1'b1;
        push_exp(1'b1, z, y);
        @(negedge clk);
        b_lsb.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({b_lsb.out_valid, b_lsb.X, b_lsb.out_last, b_lsb.err, b_lsb.in_ready} !== 8'b0_0000_001)
        begin
            n_fail++;
            $display("FAIL reset_lsb: got v=%b x=%0d l=%b e=%b r=%b want 0 0 0 0 1",
                     b_lsb.out_valid, b_lsb.X, b_lsb.out_last, b_lsb.err, b_lsb.in_ready);
        end
        n_vec++;
        if ({b_msb.out_valid, b_msb.X, b_msb.out_last, b_msb.err, b_msb.in_ready} !== 8'b0_0000_001)
        begin
            n_fail++;
            $display("FAIL reset_msb: got v=%b x=%0d l=%b e=%b r=%b want 0 0 0 0 1",
                     b_msb.out_valid, b_msb.X, b_msb.out_last, b_msb.err, b_msb.in_ready);
        end
`ifdef ENC_POPCOUNT_EN
        n_vec++;
        if (b_lsb.cnt !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d want 0", b_lsb.cnt);
        end
`endif
        rst = 1'b0;
    endtask

    // Vectors with full throughput, including mask boundaries and the 16-beat case.
    task automatic test_vectors;
        logic [17:0] tbl [4];
        tbl[0] = {2'b00, 16'h0009};
        tbl[1] = {2'b01, 16'hFF80};
        tbl[2] = {2'b10, 16'hFFFF};
        tbl[3] = {2'b01, 16'h0A50};
        b_lsb.out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            send_lsb(tbl[t][17:16], tbl[t][15:0]);
            for (int cyc = 0; cyc < 64 && sb.size() > 0; cyc++) begin
                if (cyc > 0) @(negedge clk);
                n_vec++;
                if (b_lsb.out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL vec%0d_valid: got %b want 1", t, b_lsb.out_valid);
                end else begin
                    exp_b = sb.pop_front();
                    if ({b_lsb.X, b_lsb.out_last, b_lsb.err, b_lsb.in_ready} !==
                        {exp_b.x, exp_b.last, exp_b.err, 1'b0}) begin
                        n_fail++;
                        $display("FAIL vec%0d_beat: got x=%0d l=%b e=%b r=%b want x=%0d l=%b e=%b r=0",
                                 t, b_lsb.X, b_lsb.out_last, b_lsb.err, b_lsb.in_ready,
                                 exp_b.x, exp_b.last, exp_b.err);
                    end
`ifdef ENC_POPCOUNT_EN
                    if (b_lsb.cnt !== exp_b.cnt) begin
                        n_fail++;
                        $display("FAIL vec%0d_cnt: got %0d want %0d", t, b_lsb.cnt, exp_b.cnt);
                    end
`endif
                end
            end
            if (sb.size() != 0) begin
                n_fail++;
                $display("FAIL vec%0d_timeout: got %0d beats left want 0", t, sb.size());
                sb.delete();
            end
            @(negedge clk);
            n_vec++;
            if ({b_lsb.in_ready, b_lsb.out_valid, b_lsb.X} !== 6'b10_0000) begin
                n_fail++;
                $display("FAIL vec%0d_idle: got r=%b v=%b x=%0d want r=1 v=0 x=0",
                         t, b_lsb.in_ready, b_lsb.out_valid, b_lsb.X);
            end
        end
    endtask

    task automatic test_error;
        logic [17:0] tbl [2];
        tbl[0] = {2'b11, 16'h0001};
        tbl[1] = {2'b00, 16'h00F0};
        b_lsb.out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            send_lsb(tbl[t][17:16], tbl[t][15:0]);
            for (int cyc = 0; cyc < 8 && sb.size() > 0; cyc++) begin
                if (cyc > 0) @(negedge clk);
                n_vec++;
                if (b_lsb.out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL err%0d_valid: got %b want 1", t, b_lsb.out_valid);
                end else begin
                    exp_b = sb.pop_front();
                    if ({b_lsb.X, b_lsb.out_last, b_lsb.err} !== {exp_b.x, exp_b.last, exp_b.err})
                    begin
                        n_fail++;
                        $display("FAIL err%0d_beat: got x=%0d l=%b e=%b want x=%0d l=%b e=%b",
                                 t, b_lsb.X, b_lsb.out_last, b_lsb.err,
                                 exp_b.x, exp_b.last, exp_b.err);
                    end
`ifdef ENC_POPCOUNT_EN
                    if (b_lsb.cnt !== 5'd0) begin
                        n_fail++;
                        $display("FAIL err%0d_cnt: got %0d want 0", t, b_lsb.cnt);
                    end
`endif
                end
            end
            if (sb.size() != 0) begin
                n_fail++;
                $display("FAIL err%0d_timeout: got %0d beats left want 0", t, sb.size());
                sb.delete();
            end
            @(negedge clk);
            n_vec++;
            if ({b_lsb.in_ready, b_lsb.out_valid, b_lsb.err} !== 3'b100) begin
                n_fail++;
                $display("FAIL err%0d_idle: got r=%b v=%b e=%b want r=1 v=0 e=0",
                         t, b_lsb.in_ready, b_lsb.out_valid, b_lsb.err);
            end
        end
    endtask

    // MSB-first instance: first beat must hold while the sink stalls.
    task automatic test_backpressure;
        b_msb.out_ready = 1'b0;
        @(negedge clk);
        b_msb.Z = 2'b10;
        b_msb.Y = 16'h8001;
        b_msb.in_valid = 1'b1;
        push_exp(1'b0, 2'b10, 16'h8001);
        @(negedge clk);
        b_msb.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            n_vec++;
            if ({b_msb.out_valid, b_msb.X, b_msb.out_last, b_msb.err} !==
                {1'b1, sb[0].x, sb[0].last, sb[0].err}) begin
                n_fail++;
                $display("FAIL stall%0d: got v=%b x=%0d l=%b e=%b want v=1 x=%0d l=%b e=%b",
                         k, b_msb.out_valid, b_msb.X, b_msb.out_last, b_msb.err,
                         sb[0].x, sb[0].last, sb[0].err);
            end
        end
        b_msb.out_ready = 1'b1;
        for (int cyc = 0; cyc < 8 && sb.size() > 0; cyc++) begin
            if (cyc > 0) @(negedge clk);
            n_vec++;
            if (b_msb.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_valid: got %b want 1", b_msb.out_valid);
            end else begin
                exp_b = sb.pop_front();
                if ({b_msb.X, b_msb.out_last, b_msb.err} !== {exp_b.x, exp_b.last, exp_b.err}) begin
                    n_fail++;
                    $display("FAIL bp_beat: got x=%0d l=%b e=%b want x=%0d l=%b e=%b",
                             b_msb.X, b_msb.out_last, b_msb.err, exp_b.x, exp_b.last, exp_b.err);
                end
`ifdef ENC_POPCOUNT_EN
                if (b_msb.cnt !== exp_b.cnt) begin
                    n_fail++;
                    $display("FAIL bp_cnt: got %0d want %0d", b_msb.cnt, exp_b.cnt);
                end
`endif
            end
        end
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL bp_timeout: got %0d beats left want 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        n_vec++;
        if ({b_msb.in_ready, b_msb.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_idle: got r=%b v=%b want r=1 v=0", b_msb.in_ready, b_msb.out_valid);
        end
    endtask

    // Reset lands on the same edge as the second beat's handshake and must win.
    task automatic test_reset_abort;
        b_lsb.out_ready = 1'b1;
        send_lsb(2'b01, 16'h00FF);
        for (int k = 0; k < 2; k++) begin
            if (k > 0) @(negedge clk);
            exp_b = sb.pop_front();
            n_vec++;
            if ({b_lsb.out_valid, b_lsb.X, b_lsb.out_last} !== {1'b1, exp_b.x, exp_b.last}) begin
                n_fail++;
                $display("FAIL abort_beat%0d: got v=%b x=%0d l=%b want v=1 x=%0d l=%b",
                         k, b_lsb.out_valid, b_lsb.X, b_lsb.out_last, exp_b.x, exp_b.last);
            end
        end
        sb.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            n_vec++;
            if ({b_lsb.out_valid, b_lsb.X, b_lsb.out_last, b_lsb.err, b_lsb.in_ready} !==
                8'b0_0000_001) begin
                n_fail++;
                $display("FAIL abort_idle%0d: got v=%b x=%0d l=%b e=%b r=%b want 0 0 0 0 1",
                         k, b_lsb.out_valid, b_lsb.X, b_lsb.out_last, b_lsb.err, b_lsb.in_ready);
            end
`ifdef ENC_POPCOUNT_EN
            if (b_lsb.cnt !== 5'd0) begin
                n_fail++;
                $display("FAIL abort_cnt%0d: got %0d want 0", k, b_lsb.cnt);
            end
`endif
        end
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rst    = 1'b1;
        b_lsb.in_valid = 1'b0; b_lsb.Z = 2'b00; b_lsb.Y = '0; b_lsb.out_ready = 1'b1;
        b_msb.in_valid = 1'b0; b_msb.Z = 2'b00; b_msb.Y = '0; b_msb.out_ready = 1'b1;
        test_reset();
        test_vectors();
        test_error();
        test_backpressure();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
